vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-timing generator that sits directly upstream of the sprite/image renderers (hi-hat image and siblings).
- Produces DrawX, DrawY, blank, hs and vs on vga_clk for the renderers and the VGA pins.
- Also produces frame_start and vblank_start strobes, so sequencer state only updates outside the visible region.
- Fully parameterised horizontal and vertical counters; default timing is 640x480@60 with a 25 MHz vga_clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs during the sync pulse
- VS_POL, 0, asserted level of vs during the sync pulse

Ports:
- vga_clk  in  1  pixel clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal count (0..H_TOTAL-1)
- DrawY  out  10  current vertical count (0..V_TOTAL-1)
- blank  out  1  1 = visible pixel (DrawX<H_ACTIVE && DrawY<V_ACTIVE); renderers drive colour only when 1
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- frame_start  out  1  one-cycle pulse at DrawX=0, DrawY=0
- vblank_start  out  1  one-cycle pulse at DrawX=0, DrawY=V_ACTIVE

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Interface (already decided): one clock, vga_clk; reset is synchronous and active-high.
- Counters:
  - hc advances every cycle and wraps H_TOTAL-1 -> 0.
  - vc advances only on the hc wrap cycle and wraps V_TOTAL-1 -> 0 on that same cycle (simultaneous wrap of both counters).
- DrawX=hc and DrawY=vc, both registered.
- All other outputs are registered and aligned to the same cycle as their DrawX/DrawY value (computed from next-count values); there is zero relative skew.
- hs = HS_POL when H_ACTIVE+H_FP <= hc <= H_ACTIVE+H_FP+H_SYNC-1, else ~HS_POL.
- vs = VS_POL when V_ACTIVE+V_FP <= vc <= V_ACTIVE+V_FP+V_SYNC-1, else ~VS_POL. vs changes only on a line boundary (together with hc=0).
- blank = 1 only in the visible region. Downstream ROM addressing relies on DrawX/DrawY being stable for the full cycle.
- Reset asserted:
  - Counters are forced to 0.
  - Outputs: DrawX=0, DrawY=0, blank=0, hs=~HS_POL, vs=~VS_POL, frame_start=0, vblank_start=0.
- Reset release: the first cycle after release shows DrawX=0, DrawY=0, blank=1, frame_start=1.
- Reset mid-frame: counters are abandoned immediately; no partial-line completion.
- Exactly one frame_start per V_TOTAL*H_TOTAL cycles (420000 at default timing).

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined, adds output port frame_count, out, 16 bits:
  - 0 during reset.
  - Increments by 1 on each frame_start cycle after the first post-reset frame.
  - Wraps 65535 -> 0.
  - Used by the sequencer for tempo and blink effects.
- When not defined, the port and its counter are absent and all other behaviour is identical.

Test Plan:
- Hold reset 5 cycles, then release -> during reset DrawX=0, DrawY=0, blank=0, hs=1, vs=1; first post-reset cycle DrawX=0, DrawY=0, blank=1, frame_start=1.
- Run one line -> blank falls at DrawX=640; hs=0 exactly for DrawX 656..751 (96 cycles); DrawX wraps 799->0 and DrawY steps 0->1 on the same edge.
- Run one frame -> vs=0 for DrawY 490..491 only; blank=0 for all DrawY>=480; vblank_start pulses once at (0,480); next frame_start comes 420000 cycles after the previous one.
- Assert reset at DrawX=300, DrawY=200 for 1 cycle -> next cycle counters are 0 and outputs at reset values; restart matches the first scenario.
- Parameter override H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=2, V_ACTIVE=8, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> line period 24, frame period 264 cycles, hs=1 for hc 18..21.
- With VGA_FRAME_COUNT_EN, run 3 frames -> frame_count reads 0, 1, 2 at successive frame_start pulses; force the counter to 65535 -> next frame reads 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parameterised VGA pixel/line counters producing DrawX/DrawY,
//            blank, hs, vs and frame_start/vblank_start strobes. Defining
//            VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        vblank_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    // Low for the first cycle after reset so that cycle presents pixel (0,0).
    logic       run_q;

    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;
    logic       vbs_q, vbs_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (run_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Decode from the next counts so every output lines up with DrawX/DrawY.
    always_comb begin
        blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
        hs_d    = ((hc_d >= HS_BEG) && (hc_d <= HS_END)) ? HS_POL : ~HS_POL;
        vs_d    = ((vc_d >= VS_BEG) && (vc_d <= VS_END)) ? VS_POL : ~VS_POL;
        fs_d    = (hc_d == 10'd0) && (vc_d == 10'd0);
        vbs_d   = (hc_d == 10'd0) && (vc_d == V_VIS);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            run_q   <= 1'b0;
            blank_q <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            run_q   <= 1'b1;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
        end
    end

    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign blank        = blank_q;
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;

    // The first frame after reset reads 0; later frame starts count up.
    always_comb begin
        fc_d = fc_q;
        if (run_q && fs_d) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_count = fc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed self-checking bench: default-timing instance for reset
//            and line behaviour, reduced-timing instance for frame behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       vga_clk;
    logic       reset_d;
    logic       reset_s;

    logic [9:0] dx_d, dy_d, dx_s, dy_s;
    logic       blank_d, hs_d, vs_d, fs_d, vbs_d;
    logic       blank_s, hs_s, vs_s, fs_s, vbs_s;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    int tests = 0;
    int fails = 0;

    vga_timing_gen dut_d (
        .vga_clk      (vga_clk),
        .reset        (reset_d),
        .DrawX        (dx_d),
        .DrawY        (dy_d),
        .blank        (blank_d),
        .hs           (hs_d),
        .vs           (vs_d),
        .frame_start  (fs_d),
        .vblank_start (vbs_d)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count  (fc_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (2),
        .H_SYNC   (4),
        .H_BP     (2),
        .V_ACTIVE (8),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0)
    ) dut_s (
        .vga_clk      (vga_clk),
        .reset        (reset_s),
        .DrawX        (dx_s),
        .DrawY        (dy_s),
        .blank        (blank_s),
        .hs           (hs_s),
        .vs           (vs_s),
        .frame_start  (fs_s),
        .vblank_start (vbs_s)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count  (fc_s)
`endif
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    // k = cycles since the first post-reset cycle of the default instance.
    task automatic check_def(input int k);
        int x, y;
        x = k % 800;
        y = (k / 800) % 525;
        chk($sformatf("def_x k=%0d", k), 32'(dx_d), 32'(x));
        chk($sformatf("def_y k=%0d", k), 32'(dy_d), 32'(y));
        chk($sformatf("def_blank k=%0d", k), 32'(blank_d), 32'(x < 640 && y < 480));
        chk($sformatf("def_hs k=%0d", k), 32'(hs_d), 32'(!(x >= 656 && x <= 751)));
        chk($sformatf("def_vs k=%0d", k), 32'(vs_d), 32'(!(y >= 490 && y <= 491)));
        chk($sformatf("def_fs k=%0d", k), 32'(fs_d), 32'(x == 0 && y == 0));
    endtask

    // Reduced timing: 24 cycles per line, 11 lines, 264 cycles per frame.
    task automatic check_small(input int k);
        int x, y;
        x = k % 24;
        y = (k / 24) % 11;
        chk($sformatf("sm_x k=%0d", k), 32'(dx_s), 32'(x));
        chk($sformatf("sm_y k=%0d", k), 32'(dy_s), 32'(y));
        chk($sformatf("sm_blank k=%0d", k), 32'(blank_s), 32'(x < 16 && y < 8));
        chk($sformatf("sm_hs k=%0d", k), 32'(hs_s), 32'(x >= 18 && x <= 21));
        chk($sformatf("sm_vs k=%0d", k), 32'(vs_s), 32'(y != 9));
        chk($sformatf("sm_fs k=%0d", k), 32'(fs_s), 32'(x == 0 && y == 0));
        chk($sformatf("sm_vbs k=%0d", k), 32'(vbs_s), 32'(x == 0 && y == 8));
`ifdef VGA_FRAME_COUNT_EN
        if (x == 0 && y == 0) begin
            chk($sformatf("sm_fc k=%0d", k), 32'(fc_s), 32'(k / 264));
        end
`endif
    endtask

    task automatic check_reset_small();
        chk("sm_rst_x", 32'(dx_s), 32'(0));
        chk("sm_rst_y", 32'(dy_s), 32'(0));
        chk("sm_rst_blank", 32'(blank_s), 32'(0));
        chk("sm_rst_hs", 32'(hs_s), 32'(0));
        chk("sm_rst_vs", 32'(vs_s), 32'(1));
        chk("sm_rst_fs", 32'(fs_s), 32'(0));
        chk("sm_rst_vbs", 32'(vbs_s), 32'(0));
`ifdef VGA_FRAME_COUNT_EN
        chk("sm_rst_fc", 32'(fc_s), 32'(0));
`endif
    endtask

    initial begin
        int k_d;
        int k_s;
        int hs_low;
        int fs_cnt;
        int vbs_cnt;

        reset_d = 1'b1;
        reset_s = 1'b1;
        repeat (5) tick();

        chk("def_rst_x", 32'(dx_d), 32'(0));
        chk("def_rst_y", 32'(dy_d), 32'(0));
        chk("def_rst_blank", 32'(blank_d), 32'(0));
        chk("def_rst_hs", 32'(hs_d), 32'(1));
        chk("def_rst_vs", 32'(vs_d), 32'(1));
        chk("def_rst_fs", 32'(fs_d), 32'(0));
        chk("def_rst_vbs", 32'(vbs_d), 32'(0));
        check_reset_small();

        reset_d = 1'b0;
        reset_s = 1'b0;
        tick();
        k_d = 0;
        k_s = 0;
        chk("def_rel_blank", 32'(blank_d), 32'(1));
        chk("def_rel_fs", 32'(fs_d), 32'(1));
        check_def(k_d);
        check_small(k_s);

        hs_low  = 0;
        fs_cnt  = 0;
        vbs_cnt = 0;
        for (int i = 1; i <= 900; i++) begin
            tick();
            k_d++;
            k_s++;
            check_def(k_d);
            check_small(k_s);
            if (k_d < 800 && hs_d == 1'b0) hs_low++;
            if (fs_s) fs_cnt++;
            if (vbs_s) vbs_cnt++;
        end
        chk("def_hs_low_cycles", 32'(hs_low), 32'(96));
        chk("sm_frame_starts", 32'(fs_cnt), 32'(3));
        chk("sm_vblank_starts", 32'(vbs_cnt), 32'(3));
        chk("sm_mid_x", 32'(dx_s), 32'(12));
        chk("sm_mid_y", 32'(dy_s), 32'(4));

        // One-cycle reset in the middle of a frame on the reduced instance.
        reset_s = 1'b1;
        tick();
        k_d++;
        check_def(k_d);
        check_reset_small();

        reset_s = 1'b0;
        tick();
        k_d++;
        k_s = 0;
        check_def(k_d);
        check_small(k_s);

        fs_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            k_d++;
            k_s++;
            check_def(k_d);
            check_small(k_s);
            if (fs_s) fs_cnt++;
        end
        chk("sm_restart_frame_starts", 32'(fs_cnt), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
